// File: rtl/isp_portb_arb_pkg.sv
// Shared types and defines for the instruction-RAM port-B arbiter.
// Bus width and FSM encodings mirror the project-wide defines.v entries.
`ifndef ISP_PORTB_ARB_DEFINES
`define ISP_PORTB_ARB_DEFINES
`define InstBus 31:0
`define IspProgTimeout 1024
`define IspRun 1'b0
`define IspProg 1'b1
`endif

package isp_portb_arb_pkg;

  typedef enum logic {
    ST_RUN  = `IspRun,
    ST_PROG = `IspProg
  } isp_state_e;

  localparam int unsigned CNT_W = 16;

  // Debug view of the session tracker; starve_cnt reads 0 when fairness is off.
  typedef struct packed {
    isp_state_e       state;
    logic [CNT_W-1:0] idle_cnt;
    logic [3:0]       starve_cnt;
  } isp_dbg_t;

endpackage

// File: rtl/isp_portb_arb_if.sv
// Port-B arbiter bus bundle: core load path, programmer write path and RAM port B.
// The slave modport is the arbiter side; master is the environment (core, programmer, RAM).
interface isp_portb_arb_if #(
  parameter int AW = 16
);
  import isp_portb_arb_pkg::*;

  // Handshakes: core_req is held until core_gnt; a write transfers on any clock edge
  // where prog_valid && prog_ready. Grant/ready are combinational and only rise with
  // their own request, so each accepted beat costs exactly one port-B access.
  logic            core_req;
  logic [AW-1:0]   core_addr;
  logic            core_gnt;
  logic            core_rvalid;
  logic [`InstBus] core_rdata;

  logic            prog_valid;
  logic [AW-1:0]   prog_addr;
  logic [`InstBus] prog_data;
  logic            prog_ready;

  logic            ram_enb;
  logic            ram_wen;
  logic [AW-1:0]   ram_addrb;
  logic [`InstBus] ram_din;
  logic [`InstBus] ram_doutb;

  logic            core_halt;
  logic [CNT_W-1:0] wr_cnt;

  modport slave (
    input  core_req, core_addr, prog_valid, prog_addr, prog_data, ram_doutb,
    output core_gnt, core_rvalid, core_rdata, prog_ready,
           ram_enb, ram_wen, ram_addrb, ram_din, core_halt, wr_cnt
  );

  modport master (
    output core_req, core_addr, prog_valid, prog_addr, prog_data, ram_doutb,
    input  core_gnt, core_rvalid, core_rdata, prog_ready,
           ram_enb, ram_wen, ram_addrb, ram_din, core_halt, wr_cnt
  );

endinterface

// File: rtl/isp_portb_arb.sv
// Instruction-RAM port-B arbiter: programmer writes beat core loads; tracks the download session.
// Optional fairness (core forced to win after STARVE_LIM denials): `define SPRV_ISP_ARB_FAIR_EN.
module isp_portb_arb
  import isp_portb_arb_pkg::*;
#(
  parameter int RAM_DEPTH    = 65536,
  parameter int PROG_TIMEOUT = `IspProgTimeout,
  parameter int STARVE_LIM   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  isp_portb_arb_if.slave        bus,
  output isp_dbg_t              o_dbg
);

  function automatic int clogb2(input int value);
    int result;
    result = 0;
    for (int v = value; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  localparam int AW = clogb2(RAM_DEPTH - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(PROG_TIMEOUT - 1);

  isp_state_e       r_state;
  isp_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_idle_cnt;
  logic [CNT_W-1:0] w_idle_nxt;
  logic [CNT_W-1:0] r_wr_cnt;
  logic [CNT_W-1:0] w_wr_nxt;
  logic             r_rvalid;
  logic             w_core_force;
  logic             w_prog_win;
  logic             w_core_win;
  logic [3:0]       w_starve_dbg;

`ifdef SPRV_ISP_ARB_FAIR_EN
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);
  logic [3:0] r_starve_cnt;

  assign w_core_force = bus.core_req && (r_starve_cnt == STARVE_MAX);

  // Saturating denial counter; a grant always restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_core_win) begin
      r_starve_cnt <= '0;
    end else if (bus.core_req && (r_starve_cnt != 4'hF)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  assign w_starve_dbg = r_starve_cnt;
`else
  logic [3:0] w_unused_starve_lim;
  assign w_unused_starve_lim = 4'(STARVE_LIM);
  assign w_core_force        = 1'b0;
  assign w_starve_dbg        = '0;
`endif

  assign w_prog_win = bus.prog_valid && !w_core_force;
  assign w_core_win = bus.core_req && !w_prog_win;

  always_comb begin
    bus.core_gnt   = 1'b0;
    bus.prog_ready = 1'b0;
    bus.ram_enb    = 1'b0;
    bus.ram_wen    = 1'b0;
    bus.ram_addrb  = '0;
    bus.ram_din    = '0;
    if (w_prog_win) begin
      bus.prog_ready = 1'b1;
      bus.ram_wen    = 1'b1;
      bus.ram_addrb  = AW'(bus.prog_addr);
      bus.ram_din    = bus.prog_data;
    end else if (w_core_win) begin
      bus.core_gnt  = 1'b1;
      bus.ram_enb   = 1'b1;
      bus.ram_addrb = AW'(bus.core_addr);
    end
  end

  // RAM holds doutb while enb is low, so read data needs no local capture.
  assign bus.core_rdata  = bus.ram_doutb;
  assign bus.core_rvalid = r_rvalid;
  assign bus.core_halt   = (r_state == ST_PROG);
  assign bus.wr_cnt      = r_wr_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_idle_cnt <= '0;
      r_wr_cnt   <= '0;
      r_rvalid   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_wr_cnt   <= w_wr_nxt;
      r_rvalid   <= w_core_win;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idle_nxt  = r_idle_cnt;
    w_wr_nxt    = r_wr_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_prog_win) begin
          w_state_nxt = ST_PROG;
          w_wr_nxt    = 16'd1;
          w_idle_nxt  = '0;
        end
      end
      ST_PROG: begin
        if (w_prog_win) begin
          w_wr_nxt   = r_wr_cnt + 16'd1;
          w_idle_nxt = '0;
        end else if (!bus.prog_valid) begin
          // A stalled write (fairness) is not idle time.
          if (r_idle_cnt == TIMEOUT_M1) begin
            w_state_nxt = ST_RUN;
            w_idle_nxt  = '0;
          end else if (r_idle_cnt != 16'hFFFF) begin
            w_idle_nxt = r_idle_cnt + 16'd1;
          end
        end
      end
    endcase
  end

  assign o_dbg.state      = r_state;
  assign o_dbg.idle_cnt   = r_idle_cnt;
  assign o_dbg.starve_cnt = w_starve_dbg;

endmodule

// File: tb/tb_isp_portb_arb.sv
// Self-checking bench for isp_portb_arb: RAM model, read-data scoreboard, session/fairness/reset/wrap checks.
`timescale 1ns/1ps
module tb_isp_portb_arb;
  import isp_portb_arb_pkg::*;

  localparam int AW = 16;
  localparam int TO = 8;
  localparam int SL = 4;
`ifdef SPRV_ISP_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  isp_portb_arb_if #(.AW(AW)) bus ();
  isp_dbg_t dbg;

  isp_portb_arb #(
    .RAM_DEPTH   (65536),
    .PROG_TIMEOUT(TO),
    .STARVE_LIM  (SL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .o_dbg(dbg)
  );

  // ---------------- RAM model ----------------
  logic [31:0] ram    [0:65535];
  logic [31:0] shadow [0:65535];

  always @(posedge clk) begin
    if (bus.ram_wen) ram[bus.ram_addrb] <= bus.ram_din;
    if (bus.ram_enb) bus.ram_doutb <= ram[bus.ram_addrb];
  end

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.core_rvalid) begin
        if (exp_q.size() == 0) check("rvalid_unexpected", 32'd1, 32'd0);
        else check("rdata", bus.core_rdata, exp_q.pop_front());
      end
      if (bus.core_gnt) exp_q.push_back(shadow[bus.core_addr]);
      if (bus.prog_ready) shadow[bus.prog_addr] = bus.prog_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_core(input logic req, input logic [AW-1:0] addr);
    bus.core_req  = req;
    bus.core_addr = addr;
  endtask

  task automatic drive_prog(input logic valid, input logic [AW-1:0] addr, input logic [31:0] data);
    bus.prog_valid = valid;
    bus.prog_addr  = addr;
    bus.prog_data  = data;
  endtask

  task automatic wait_halt_low(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.core_halt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("halt_fall", 32'(bus.core_halt), 32'd0);
    check("state_run", 32'(dbg.state), 32'(ST_RUN));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic g;
    drive_core(1'b0, '0);
    drive_prog(1'b0, '0, '0);
    bus.ram_doutb = '0;
    for (int i = 0; i < 65536; i++) begin
      ram[i]    = 32'h0;
      shadow[i] = 32'h0;
    end
    ram[16'h10] = 32'hA5A5_0010; shadow[16'h10] = 32'hA5A5_0010;
    ram[16'h11] = 32'hA5A5_0011; shadow[16'h11] = 32'hA5A5_0011;

    // Reset state
    rst_n = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_rvalid", 32'(bus.core_rvalid), 32'd0);
    check("rst_halt",   32'(bus.core_halt), 32'd0);
    check("rst_wr_cnt", 32'(bus.wr_cnt), 32'd0);
    check("rst_state",  32'(dbg.state), 32'(ST_RUN));
    check("idle_gnt",   32'(bus.core_gnt), 32'd0);
    check("idle_ready", 32'(bus.prog_ready), 32'd0);
    check("idle_ram",   {bus.ram_enb, bus.ram_wen, 14'd0, bus.ram_addrb}, 32'd0);
    check("idle_din",   bus.ram_din, 32'd0);
    tick();
    rst_n = 1'b1;

    // Core-only back-to-back reads
    tick();
    drive_core(1'b1, 16'h10);
    @(negedge clk);
    check("rd0_gnt",   32'(bus.core_gnt), 32'd1);
    check("rd0_enb",   {bus.ram_enb, bus.ram_wen}, 32'd2);
    check("rd0_addrb", 32'(bus.ram_addrb), 32'h10);
    tick();
    drive_core(1'b1, 16'h11);
    @(negedge clk);
    check("rd1_gnt",    32'(bus.core_gnt), 32'd1);
    check("rd1_rvalid", 32'(bus.core_rvalid), 32'd1);
    tick();
    drive_core(1'b0, '0);
    @(negedge clk);
    check("rd2_rvalid", 32'(bus.core_rvalid), 32'd1);
    check("rd2_halt",   32'(bus.core_halt), 32'd0);

    // Contention: programmer wins, read-after-write returns new data
    tick();
    drive_prog(1'b1, 16'h20, 32'hDEAD_BEEF);
    drive_core(1'b1, 16'h20);
    @(negedge clk);
    check("ct_ready", 32'(bus.prog_ready), 32'd1);
    check("ct_gnt",   32'(bus.core_gnt), 32'd0);
    check("ct_ram",   {bus.ram_enb, bus.ram_wen, 14'd0, bus.ram_addrb}, 32'h4000_0020);
    check("ct_din",   bus.ram_din, 32'hDEAD_BEEF);
    tick();
    drive_prog(1'b0, '0, '0);
    @(negedge clk);
    check("ct_gnt2", 32'(bus.core_gnt), 32'd1);
    check("ct_halt", 32'(bus.core_halt), 32'd1);
    tick();
    drive_core(1'b0, '0);
    @(negedge clk);
    check("ct_rdata", bus.core_rdata, 32'hDEAD_BEEF);
    wait_halt_low(4 * TO);

    // Session: 3 writes then idle until timeout
    tick();
    drive_prog(1'b1, 16'h30, $urandom);
    @(negedge clk);
    check("ss_halt_w1", 32'(bus.core_halt), 32'd0);
    tick();
    drive_prog(1'b1, 16'h31, $urandom);
    @(negedge clk);
    check("ss_halt_w2", 32'(bus.core_halt), 32'd1);
    tick();
    drive_prog(1'b1, 16'h32, $urandom);
    tick();
    drive_prog(1'b0, '0, '0);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      check("ss_halt_idle", 32'(bus.core_halt), 32'd1);
      check("ss_wr_cnt",    32'(bus.wr_cnt), 32'd3);
      tick();
    end
    @(negedge clk);
    check("ss_halt_end",  32'(bus.core_halt), 32'd0);
    check("ss_state_end", 32'(dbg.state), 32'(ST_RUN));
    check("ss_wr_hold",   32'(bus.wr_cnt), 32'd3);

    // Starvation: 10 cycles of writes with a pending core load
    tick();
    drive_core(1'b1, 16'h11);
    for (int i = 1; i <= 10; i++) begin
      logic exp_g;
      drive_prog(1'b1, 16'(16'h50 + i), $urandom);
      exp_g = FAIR && (i == SL + 1);
      @(negedge clk);
      check("sv_gnt",   32'(bus.core_gnt), 32'(exp_g));
      check("sv_ready", 32'(bus.prog_ready), 32'(!exp_g));
      g = bus.core_gnt;
      tick();
      if (g) drive_core(1'b0, '0);
    end
    drive_prog(1'b0, '0, '0);
    @(negedge clk);
    check("sv_gnt_after", 32'(bus.core_gnt), 32'(!FAIR));
    tick();
    drive_core(1'b0, '0);
    wait_halt_low(4 * TO);

    // Reset mid-operation: read issued in the reset cycle, while in PROG
    tick();
    drive_prog(1'b1, 16'h60, $urandom);
    tick();
    drive_prog(1'b0, '0, '0);
    drive_core(1'b1, 16'h10);
    rst_n = 1'b0;
    @(negedge clk);
    check("rm_gnt",  32'(bus.core_gnt), 32'd1);
    check("rm_halt", 32'(bus.core_halt), 32'd1);
    tick();
    rst_n = 1'b1;
    drive_core(1'b0, '0);
    @(negedge clk);
    check("rm_rvalid", 32'(bus.core_rvalid), 32'd0);
    check("rm_halt0",  32'(bus.core_halt), 32'd0);
    check("rm_wr_cnt", 32'(bus.wr_cnt), 32'd0);
    check("rm_state",  32'(dbg.state), 32'(ST_RUN));

    // wr_cnt wrap: 65536 writes in one session
    tick();
    for (int i = 0; i < 65536; i++) begin
      drive_prog(1'b1, 16'(i), $urandom);
      if (i == 65535) begin
        @(negedge clk);
        check("wr_cnt_ffff", 32'(bus.wr_cnt), 32'h0000_FFFF);
      end
      tick();
    end
    drive_prog(1'b0, '0, '0);
    @(negedge clk);
    check("wr_cnt_wrap", 32'(bus.wr_cnt), 32'd0);
    check("wrap_halt",   32'(bus.core_halt), 32'd1);
    check("wrap_state",  32'(dbg.state), 32'(ST_PROG));
    tick();
    drive_core(1'b1, 16'(16'h1000 + $urandom_range(0, 255)));
    @(negedge clk);
    check("wrap_rd_gnt", 32'(bus.core_gnt), 32'd1);
    tick();
    drive_core(1'b0, '0);
    wait_halt_low(4 * TO);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
